// File: rtl/tile_accumulator.sv
// tile_accumulator
//
// Output-side stage sitting directly behind the matrix multiply-accumulate
// unit. It holds the running M x N int32 accumulator and feeds it back into
// the MAC unit's C input, so successive K-tiles accumulate as D = A*B + C.
// Every accepted D matrix simply replaces the accumulator; the addition itself
// happens inside the MAC unit.
//
// Once the programmed number of tiles has arrived, or a tile arrives flagged
// with last_in, the block drains the accumulator one row per handshake over a
// valid/ready stream toward writeback, then returns to accumulating.

module tile_accumulator #(
  parameter  int M      = 4,
  parameter  int N      = 4,
  parameter  int CNT_W  = 8,
  localparam int RIDX_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,

  // Tile stream from the MAC unit
  input  logic signed [M-1:0][N-1:0][31:0] D_in,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  logic                            last_in,
  input  logic        [CNT_W-1:0]         num_tiles,

  // Accumulator fed back to the MAC unit's C operand
  output logic signed [M-1:0][N-1:0][31:0] C_out,

  // Row drain stream toward writeback
  output logic signed [N-1:0][31:0]        row_out,
  output logic        [RIDX_W-1:0]        row_idx,
  output logic                            valid_out,
  input  logic                            ready_out,

  // Progress within the current output matrix
  output logic        [CNT_W-1:0]         tile_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(M - 1);

  state_t                           state;
  logic signed [M-1:0][N-1:0][31:0] acc;
  logic        [CNT_W-1:0]          target;

  logic                             tile_fire;
  logic                             row_fire;
  logic                             first_tile;
  logic        [CNT_W-1:0]          num_eff;
  logic        [CNT_W-1:0]          cur_target;
  logic        [CNT_W:0]            cnt_next;
  logic                             is_last;

  // Handshakes are decoded purely from the state register so neither ready_in
  // nor valid_out ever combinationally depends on the opposite-side handshake.
  assign ready_in  = (state == ACCUM);
  assign valid_out = (state == DRAIN);
  assign tile_fire = valid_in  && ready_in;
  assign row_fire  = valid_out && ready_out;

  // Work out whether the tile being offered closes the matrix. On the first
  // tile the target register is not loaded yet, so compare against the live
  // num_tiles (with 0 promoted to 1); later tiles use the latched target so
  // mid-matrix num_tiles changes are ignored.
  always_comb begin
    first_tile = (tile_cnt == '0);
    num_eff    = (num_tiles == '0) ? CNT_W'(1) : num_tiles;
    cur_target = first_tile ? num_eff : target;
    cnt_next   = {1'b0, tile_cnt} + {{CNT_W{1'b0}}, 1'b1};
    is_last    = last_in || (cnt_next == {1'b0, cur_target});
  end

  // C operand back to the MAC unit: zero for the first tile of a matrix so the
  // previous result never leaks in, otherwise the frozen accumulator. Only
  // registers feed this, never D_in.
  always_comb begin
    C_out = acc;
    if (state == ACCUM && first_tile) begin
      C_out = '0;
    end
  end

  // Drained row is the addressed accumulator row while draining, and held at
  // zero otherwise so idle writeback sees a clean bus.
  always_comb begin
    row_out = '0;
    if (state == DRAIN) begin
      row_out = acc[row_idx];
    end
  end

  // Main controller: captures tiles and counts them while accumulating, then
  // walks the row index while draining. The accumulator is only written on a
  // tile accept, which cannot happen in DRAIN, so it is frozen there.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ACCUM;
      acc      <= '0;
      target   <= CNT_W'(1);
      tile_cnt <= '0;
      row_idx  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (tile_fire) begin
            acc <= D_in;
            if (first_tile) begin
              target <= num_eff;
            end
            if (is_last) begin
              tile_cnt <= '0;
              row_idx  <= '0;
              state    <= DRAIN;
            end else begin
              tile_cnt <= cnt_next[CNT_W-1:0];
            end
          end
        end
        DRAIN: begin
          if (row_fire) begin
            if (row_idx == LAST_ROW) begin
              row_idx <= '0;
              state   <= ACCUM;
            end else begin
              row_idx <= row_idx + RIDX_W'(1);
            end
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_accumulator.sv
// tb_tile_accumulator
//
// Directed bench for tile_accumulator with the default 4x4 geometry. Each
// scenario task drives its own stimulus and compares against hand-computed
// values. Inputs change and outputs are sampled 1 time unit after the rising
// edge, well away from the active edge.

module tb_tile_accumulator;

  localparam int M      = 4;
  localparam int N      = 4;
  localparam int CNT_W  = 8;
  localparam int RIDX_W = 2;

  logic                             clk_i;
  logic                             rst_ni;
  logic signed [M-1:0][N-1:0][31:0] D_in;
  logic                             valid_in;
  logic                             ready_in;
  logic                             last_in;
  logic        [CNT_W-1:0]          num_tiles;
  logic signed [M-1:0][N-1:0][31:0] C_out;
  logic signed [N-1:0][31:0]        row_out;
  logic        [RIDX_W-1:0]         row_idx;
  logic                             valid_out;
  logic                             ready_out;
  logic        [CNT_W-1:0]          tile_cnt;

  int errors = 0;
  int checks = 0;

  tile_accumulator #(.M(M), .N(N), .CNT_W(CNT_W)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .D_in      (D_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .last_in   (last_in),
    .num_tiles (num_tiles),
    .C_out     (C_out),
    .row_out   (row_out),
    .row_idx   (row_idx),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .tile_cnt  (tile_cnt)
  );

  // Free-running 10-unit clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Fill a whole matrix with one value
  function automatic logic signed [M-1:0][N-1:0][31:0] fill_mat(input logic [31:0] v);
    logic signed [M-1:0][N-1:0][31:0] m;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = v;
    return m;
  endfunction

  // Fill a single row with one value
  function automatic logic signed [N-1:0][31:0] fill_row(input logic [31:0] v);
    logic signed [N-1:0][31:0] rw;
    for (int c = 0; c < N; c++)
      rw[c] = v;
    return rw;
  endfunction

  // Reset values must appear asynchronously and hold through reset
  task automatic test_reset();
    rst_ni    = 1'b0;
    valid_in  = 1'b0;
    last_in   = 1'b0;
    ready_out = 1'b0;
    num_tiles = '0;
    D_in      = '0;
    #1;
    checks++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: ready_in=%b valid_out=%b, required 1 0", ready_in, valid_out);
    end
    checks++;
    if (C_out !== '0 || row_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: C_out=%h row_out=%h, required zero", C_out, row_out);
    end
    checks++;
    if (tile_cnt !== '0 || row_idx !== '0) begin
      errors++;
      $display("[TB] FAIL reset_counters: tile_cnt=%0d row_idx=%0d, required 0 0", tile_cnt, row_idx);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  // One tile with num_tiles=1 drains immediately as four all-5 rows
  task automatic test_single_tile();
    num_tiles = 8'd1;
    D_in      = fill_mat(32'd5);
    valid_in  = 1'b1;
    ready_out = 1'b1;
    checks++;
    if (C_out !== '0 || ready_in !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_accept: C_out=%h ready_in=%b, required zero 1", C_out, ready_in);
    end
    tick();
    valid_in = 1'b0;
    for (int r = 0; r < M; r++) begin
      checks++;
      if (valid_out !== 1'b1 || row_idx !== RIDX_W'(r) || row_out !== fill_row(32'd5)) begin
        errors++;
        $display("[TB] FAIL single_row%0d: valid_out=%b row_idx=%0d row_out=%h, required 1 %0d all-5",
                 r, valid_out, row_idx, row_out, r);
      end
      tick();
    end
    checks++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: ready_in=%b valid_out=%b, required 1 0", ready_in, valid_out);
    end
  endtask

  // Three tiles through an MMA model D = A*B + C with A*B = 2 everywhere
  // (K=2, A and B all ones). num_tiles is changed after the first tile and
  // must be ignored.
  task automatic test_accumulation();
    logic signed [M-1:0][N-1:0][31:0] d;
    num_tiles = 8'd3;
    ready_out = 1'b1;
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (tile_cnt !== CNT_W'(t) || C_out !== fill_mat(32'(2 * t))) begin
        errors++;
        $display("[TB] FAIL accum_tile%0d: tile_cnt=%0d C_out[0][0]=%0d, required %0d %0d",
                 t, tile_cnt, C_out[0][0], t, 2 * t);
      end
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          d[r][c] = (1 * 1 + 1 * 1) + C_out[r][c];
      D_in     = d;
      valid_in = 1'b1;
      tick();
      if (t == 0) num_tiles = 8'd1;
    end
    valid_in = 1'b0;
    for (int r = 0; r < M; r++) begin
      checks++;
      if (valid_out !== 1'b1 || row_idx !== RIDX_W'(r) || row_out !== fill_row(32'd6)) begin
        errors++;
        $display("[TB] FAIL accum_row%0d: valid_out=%b row_idx=%0d row_out=%h, required 1 %0d all-6",
                 r, valid_out, row_idx, row_out, r);
      end
      tick();
    end
  endtask

  // num_tiles=4 but last_in on the second tile ends the matrix early
  task automatic test_early_last();
    num_tiles = 8'd4;
    ready_out = 1'b1;
    D_in      = fill_mat(32'd1);
    valid_in  = 1'b1;
    last_in   = 1'b0;
    tick();
    checks++;
    if (tile_cnt !== 8'd1 || valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL early_first: tile_cnt=%0d valid_out=%b, required 1 0", tile_cnt, valid_out);
    end
    D_in    = fill_mat(32'd9);
    last_in = 1'b1;
    tick();
    valid_in = 1'b0;
    last_in  = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || row_idx !== '0 || tile_cnt !== '0 || row_out !== fill_row(32'd9)) begin
      errors++;
      $display("[TB] FAIL early_drain: valid_out=%b row_idx=%0d tile_cnt=%0d row_out=%h, required 1 0 0 all-9",
               valid_out, row_idx, tile_cnt, row_out);
    end
    for (int r = 0; r < M; r++) tick();
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("[TB] FAIL early_done: ready_in=%b, required 1", ready_in);
    end
  endtask

  // Stall on row 1 for five cycles while offering ignored tiles
  task automatic test_backpressure();
    logic signed [M-1:0][N-1:0][31:0] d;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        d[r][c] = 32'(100 * r + c);
    num_tiles = 8'd1;
    D_in      = d;
    valid_in  = 1'b1;
    ready_out = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    ready_out = 1'b0;
    D_in      = fill_mat(32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      valid_in = k[0];
      checks++;
      if (row_idx !== 2'd1 || row_out !== d[1] || ready_in !== 1'b0 || valid_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_cyc%0d: row_idx=%0d row_out=%h ready_in=%b valid_out=%b, required 1 %h 0 1",
                 k, row_idx, row_out, ready_in, valid_out, d[1]);
      end
      tick();
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    for (int r = 1; r < M; r++) begin
      checks++;
      if (row_idx !== RIDX_W'(r) || row_out !== d[r]) begin
        errors++;
        $display("[TB] FAIL stall_row%0d: row_idx=%0d row_out=%h, required %0d %h",
                 r, row_idx, row_out, r, d[r]);
      end
      tick();
    end
    checks++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_done: ready_in=%b valid_out=%b, required 1 0", ready_in, valid_out);
    end
  endtask

  // num_tiles=0 acts as 1, max positive value passes untouched, and
  // last_in coinciding with a count hit produces a single drain
  task automatic test_edge_values();
    num_tiles = 8'd0;
    ready_out = 1'b1;
    D_in      = fill_mat(32'h7FFF_FFFF);
    valid_in  = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int r = 0; r < M; r++) begin
      checks++;
      if (valid_out !== 1'b1 || row_out !== fill_row(32'h7FFF_FFFF)) begin
        errors++;
        $display("[TB] FAIL edge_max_row%0d: valid_out=%b row_out=%h, required 1 all-7fffffff",
                 r, valid_out, row_out);
      end
      tick();
    end
    num_tiles = 8'd2;
    D_in      = fill_mat(32'd3);
    valid_in  = 1'b1;
    tick();
    D_in    = fill_mat(32'hFFFF_FFFF);
    last_in = 1'b1;
    tick();
    valid_in = 1'b0;
    last_in  = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || row_out !== fill_row(32'hFFFF_FFFF)) begin
      errors++;
      $display("[TB] FAIL edge_both_start: valid_out=%b row_out=%h, required 1 all-ffffffff", valid_out, row_out);
    end
    for (int r = 0; r < M; r++) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (valid_out !== 1'b0 || ready_in !== 1'b1 || tile_cnt !== '0) begin
        errors++;
        $display("[TB] FAIL edge_single_drain%0d: valid_out=%b ready_in=%b tile_cnt=%0d, required 0 1 0",
                 k, valid_out, ready_in, tile_cnt);
      end
      tick();
    end
  endtask

  // Reset lands at row 2 of a drain; afterwards a fresh matrix starts clean
  task automatic test_reset_mid_drain();
    num_tiles = 8'd1;
    ready_out = 1'b1;
    D_in      = fill_mat(32'd11);
    valid_in  = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    checks++;
    if (row_idx !== 2'd2 || valid_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre: row_idx=%0d valid_out=%b, required 2 1", row_idx, valid_out);
    end
    #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || C_out !== '0 || row_out !== '0 || ready_in !== 1'b1 || row_idx !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_async: valid_out=%b C_out=%h row_out=%h ready_in=%b row_idx=%0d, required 0 zero zero 1 0",
               valid_out, C_out, row_out, ready_in, row_idx);
    end
    tick();
    rst_ni    = 1'b1;
    num_tiles = 8'd2;
    D_in      = fill_mat(32'd7);
    valid_in  = 1'b1;
    checks++;
    if (C_out !== '0 || tile_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_first: C_out=%h tile_cnt=%0d, required zero 0", C_out, tile_cnt);
    end
    tick();
    valid_in = 1'b0;
    checks++;
    if (tile_cnt !== 8'd1 || C_out !== fill_mat(32'd7) || valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_second: tile_cnt=%0d C_out[0][0]=%0d valid_out=%b, required 1 7 0",
               tile_cnt, C_out[0][0], valid_out);
    end
    D_in     = fill_mat(32'd8);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || row_out !== fill_row(32'd8)) begin
      errors++;
      $display("[TB] FAIL midrst_drain: valid_out=%b row_out=%h, required 1 all-8", valid_out, row_out);
    end
    for (int r = 0; r < M; r++) tick();
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_single_tile();
    test_accumulation();
    test_early_last();
    test_backpressure();
    test_edge_values();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_accumulator.md
# tile_accumulator

Output-side stage placed directly downstream of the matrix multiply-accumulate unit. It holds the running M×N int32 accumulator and drives it back into the MAC unit's C input, so that successive K-tiles accumulate as D = A·B + C. Each accepted D matrix is captured into the accumulator. After a programmed number of tiles, or an early `last_in`, the block drains the result row by row over a valid/ready stream toward the writeback path.

## Interface
Parameters:
- `M`, default 4: rows of the result matrix; must match the MAC unit's M.
- `N`, default 4: columns of the result matrix; must match the MAC unit's N.
- `CNT_W`, default 8: width of the tile counter and of `num_tiles`.

Ports:
- `clk_i`  in  1: single clock; all state updates on the rising edge.
- `rst_ni`  in  1: reset, asynchronous and active-low.
- `D_in`  in  [M][N]×32 signed: result matrix from the MAC unit.
- `valid_in`  in  1: `D_in` valid (the MAC unit's `valid_out`).
- `ready_in`  out  1: block can accept a tile (drives the MAC unit's `ready_out`).
- `last_in`  in  1: sideband, qualified by `valid_in`; marks the accepted tile as the final one.
- `num_tiles`  in  CNT_W: number of K-tiles per output matrix; sampled on the first tile of a matrix.
- `C_out`  out  [M][N]×32 signed: accumulator value fed to the MAC unit's C input.
- `row_out`  out  [N]×32 signed: current drained row.
- `row_idx`  out  clog2(M) (minimum 1 bit): index of `row_out`.
- `valid_out`  out  1: `row_out` valid.
- `ready_out`  in  1: downstream accepts the row.
- `tile_cnt`  out  CNT_W: tiles accumulated so far in the current matrix.

## Operation
- State machine has two states: ACCUM and DRAIN.
- ACCUM behaviour:
  - `ready_in` = 1 and `valid_out` = 0.
  - `C_out` = all zeros when `tile_cnt` == 0; otherwise `C_out` = accumulator register.
  - `C_out` is a pure function of registers. There is no combinational path from `D_in` to `C_out`.
- Tile accept (`valid_in` && `ready_in`):
  - Accumulator ← `D_in`. Summation already happened inside the MAC unit through `C_out`; this block adds nothing.
  - If `tile_cnt` == 0, latch `num_tiles` into a target register. A `num_tiles` value of 0 is treated as 1.
  - The tile is last when `tile_cnt`+1 == target, or when `last_in` = 1. If both hold, one drain results.
  - On a last tile: `tile_cnt` ← 0, `row_idx` ← 0, next state DRAIN.
  - On any other tile: `tile_cnt` ← `tile_cnt`+1.
- DRAIN behaviour:
  - `ready_in` = 0 and `valid_out` = 1.
  - `row_out` = accumulator[`row_idx`].
  - `C_out` = accumulator.
  - The accumulator is frozen while in DRAIN.
- Row accept (`valid_out` && `ready_out`):
  - If `row_idx` < M-1, `row_idx` increments.
  - If `row_idx` == M-1, next state is ACCUM and `row_idx` ← 0.
  - `valid_out` may be held high with `ready_out` low indefinitely. `row_out` and `row_idx` must stay stable while stalled.
- Arithmetic and widths:
  - Values are 32-bit two's complement; wrap-around follows the MAC unit.
  - `tile_cnt` never exceeds target-1. A target of 2^CNT_W-1 is the maximum.
- Reset, at any time including mid-DRAIN, gives:
  - state = ACCUM
  - accumulator = 0, `tile_cnt` = 0, `row_idx` = 0
  - `valid_out` = 0, `ready_in` = 1, `C_out` = 0, `row_out` = 0
  - Any partial matrix is discarded.

## Timing
- Tile accept in cycle t: the accumulator shows `D_in` at t+1, and `C_out` shows it at t+1.
- Last tile accepted at t: `valid_out` = 1 at t+1 with `row_idx` = 0.
- Minimum drain time is M cycles when `ready_out` is held high.
- Final row accepted at t: `ready_in` = 1 at t+1.
- Minimum matrix period is num_tiles + M cycles.
- `ready_in` does not depend on `valid_in`, and `valid_out` does not depend on `ready_out`. Both are decoded from state only.
- `num_tiles` changes after the first tile of a matrix have no effect until the next matrix.

## Test plan
- **Single tile:** reset, `num_tiles`=1, one tile with all D=5, `ready_out`=1. Required: `C_out`=0 during the accept, then rows 0..M-1 each all-5 on consecutive cycles, then `ready_in`=1.
- **Accumulation loop:** `num_tiles`=3, with an MMA model computing D=A·B+`C_out`, each tile contributing 2 per element. Required: `C_out` is 0, then 2, then 4 across the three accepts; drained rows all equal 6; `tile_cnt` reads 0, 1, 2.
- **Early last:** `num_tiles`=4, `last_in`=1 on the 2nd tile. Required: drain starts the cycle after the 2nd accept, and `tile_cnt` returns to 0.
- **Backpressure:** during DRAIN, hold `ready_out`=0 for 5 cycles on row 1. Required: `row_idx`=1 and `row_out` are stable, `ready_in`=0 throughout, and `valid_in` pulses are ignored.
- **Edge values:** `num_tiles`=0 behaves as 1. D=0x7FFFFFFF is drained unchanged. `last_in` together with a count hit gives exactly one drain.
- **Reset mid-drain:** assert `rst_ni`=0 at `row_idx`=2 of a drain. Required: `valid_out`=0 and `C_out`=0 asynchronously; after release, the next tile behaves as a first tile.
